// File: rtl/sync_fifo_ctrl_if.sv
// Bus between the producer/consumer side and sync_fifo_ctrl.
// The overflow/underflow flags exist only when SYNC_FIFO_ERR_EN is defined.
//
// Request semantics: push and pop are plain per-cycle requests that the FIFO
// samples at the rising clock edge. A push is accepted when the FIFO is
// not full, or when a pop happens in the same cycle. A pop is accepted when
// the FIFO is not empty. A request that is not accepted is dropped, not held.
// rd_data shows the head word (first-word-fall-through) and is meaningful
// only while empty is 0.
interface sync_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              push;
  logic [DATA_W-1:0] wr_data;
  logic              pop;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
`ifdef SYNC_FIFO_ERR_EN
  logic              overflow;
  logic              underflow;

  modport master (output push, wr_data, pop,
                  input  rd_data, count, full, empty, overflow, underflow);
  modport slave  (input  push, wr_data, pop,
                  output rd_data, count, full, empty, overflow, underflow);
`else
  modport master (output push, wr_data, pop,
                  input  rd_data, count, full, empty);
  modport slave  (input  push, wr_data, pop,
                  output rd_data, count, full, empty);
`endif
endinterface

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock first-word-fall-through FIFO controller.
// Storage, read/write pointers and an occupancy counter. The counter is the
// only control state and is exposed directly on bus.count. full/empty are
// decoded from it.
// Optional feature: define SYNC_FIFO_ERR_EN to add sticky overflow and
// underflow flags on the bus.
module sync_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active-low
  sync_fifo_ctrl_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full, empty;
  logic              wr_en, rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A push while full is still taken if a pop frees the head slot at the
  // same edge. A pop while empty is never taken, even with a push.
  assign wr_en = bus.push & (~full | bus.pop);
  assign rd_en = bus.pop & ~empty;

  // Next-state for the pointers and occupancy. Pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_en && !rd_en)      count_d = count_q + CNT_W'(1);
    else if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  // Head word straight from storage. When full with push+pop, the write
  // lands in this same slot only after the edge, so the old head is read.
  assign bus.rd_data = mem_q[rd_ptr_q];
  assign bus.count   = count_q;
  assign bus.full    = full;
  assign bus.empty   = empty;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, underflow_q;

  // Sticky error flags: a dropped push or an ignored pop, held until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.push && full && !bus.pop) overflow_q  <= 1'b1;
      if (bus.pop && empty)             underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  // Without the error flags, dropped pushes and ignored pops are silent.
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: queue-based reference model, a per-cycle compare
// process, and directed sequences with literal expectations.
module tb_sync_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   checks;
  int   failures;

  sync_fifo_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf;
  logic              m_unf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_ovf <= 1'b0;
      m_unf <= 1'b0;
    end else begin
      if (bus.push && exp_q.size() == DEPTH && !bus.pop) m_ovf <= 1'b1;
      if (bus.pop && exp_q.size() == 0)                  m_unf <= 1'b1;
      if (bus.push && bus.pop) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(bus.wr_data);
        end else begin
          void'(exp_q.pop_front());
          exp_q.push_back(bus.wr_data);
        end
      end else if (bus.push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(bus.wr_data);
      end else if (bus.pop) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cmp_count", 32'(bus.count), 32'(exp_q.size()));
      chk("cmp_full",  32'(bus.full),  32'(exp_q.size() == DEPTH));
      chk("cmp_empty", 32'(bus.empty), 32'(exp_q.size() == 0));
      if (exp_q.size() != 0) chk("cmp_rd_data", 32'(bus.rd_data), 32'(exp_q[0]));
`ifdef SYNC_FIFO_ERR_EN
      chk("cmp_overflow",  32'(bus.overflow),  32'(m_ovf));
      chk("cmp_underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    end
  end

  // ---------------- driver ----------------
  // Inputs change 2 time units after a rising edge, so the next edge samples them.
  task automatic drive(input logic p, input logic [DATA_W-1:0] d, input logic q);
    @(posedge clk);
    #2;
    bus.push    = p;
    bus.wr_data = d;
    bus.pop     = q;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic fill4();
    drive(1'b1, 8'hA1, 1'b0);
    drive(1'b1, 8'hA2, 1'b0);
    drive(1'b1, 8'hA3, 1'b0);
    drive(1'b1, 8'hA4, 1'b0);
    idle();
  endtask

  // Pop one word, first checking it is the current head.
  task automatic pop_expect(input string name, input logic [DATA_W-1:0] exp);
    chk(name, 32'(bus.rd_data), 32'(exp));
    drive(1'b0, '0, 1'b1);
    idle();
  endtask

  // ---------------- directed sequences ----------------
  initial begin
    logic [DATA_W-1:0] d;
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst_n    = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.wr_data = '0;

    // Reset then idle: asynchronous effect, checked before any edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle();
    idle();

    // Fill and drain.
    fill4();
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_full",  32'(bus.full),  32'd1);
    pop_expect("drain_0", 8'hA1);
    pop_expect("drain_1", 8'hA2);
    pop_expect("drain_2", 8'hA3);
    pop_expect("drain_3", 8'hA4);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Overflow: push into a full FIFO with no pop is dropped.
    fill4();
    drive(1'b1, 8'hFF, 1'b0);
    idle();
    chk("ovf_count", 32'(bus.count),   32'd4);
    chk("ovf_head",  32'(bus.rd_data), 32'hA1);
`ifdef SYNC_FIFO_ERR_EN
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
`endif

    // Simultaneous push/pop while full: 0x66 becomes the tail.
    drive(1'b1, 8'h66, 1'b1);
    idle();
    chk("full_pp_count", 32'(bus.count),   32'd4);
    chk("full_pp_head",  32'(bus.rd_data), 32'hA2);
    pop_expect("full_pp_0", 8'hA2);
    pop_expect("full_pp_1", 8'hA3);
    pop_expect("full_pp_2", 8'hA4);
    pop_expect("full_pp_3", 8'h66);
    chk("full_pp_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push/pop while empty: push taken, pop ignored.
    drive(1'b1, 8'h55, 1'b1);
    idle();
    chk("empty_pp_count", 32'(bus.count),   32'd1);
    chk("empty_pp_data",  32'(bus.rd_data), 32'h55);
`ifdef SYNC_FIFO_ERR_EN
    chk("unf_flag",      32'(bus.underflow), 32'd1);
    chk("ovf_flag_held", 32'(bus.overflow),  32'd1);
`endif
    pop_expect("empty_pp_pop", 8'h55);

    // Pointer wrap: alternating push/pop with incrementing data.
    for (int i = 0; i < 10; i++) begin
      d = 8'(8'h10 + i);
      drive(1'b1, d, 1'b0);
      drive(1'b0, '0, 1'b1);
      chk("wrap_count1", 32'(bus.count),   32'd1);
      chk("wrap_data",   32'(bus.rd_data), 32'(d));
      idle();
      chk("wrap_count0", 32'(bus.count),   32'd0);
    end

    // Reset mid-operation with three entries queued.
    drive(1'b1, 8'hB1, 1'b0);
    drive(1'b1, 8'hB2, 1'b0);
    drive(1'b1, 8'hB3, 1'b0);
    idle();
    chk("mid_count3", 32'(bus.count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(bus.count), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
`ifdef SYNC_FIFO_ERR_EN
    chk("mid_rst_ovf", 32'(bus.overflow),  32'd0);
    chk("mid_rst_unf", 32'(bus.underflow), 32'd0);
`endif
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    idle();
    chk("post_rst_count", 32'(bus.count), 32'd1);
    pop_expect("post_rst_pop", 8'h77);
    chk("post_rst_empty", 32'(bus.empty), 32'd1);

    idle();
    idle();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Single-clock FIFO built from storage, read/write pointers and an occupancy counter. It accepts push/pop requests from the producer and consumer, turns them into accepted write and read strobes, and presents head-of-queue data in first-word-fall-through form. It sits between a producer stage and a consumer stage in the FIFO subsystem and is the sole owner of the full/empty status.

## Interface
- `DATA_W`, 8, width of each stored word.
- `DEPTH`, 4, number of entries. Must be a power of two, ≥2.
- `CNT_W`, $clog2(DEPTH)+1, occupancy width, derived. Not overridden.

- `clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk` upstream.
- `push`  in  1  write request.
- `wr_data`  in  DATA_W  word written on an accepted push.
- `pop`  in  1  read request.
- `rd_data`  out  DATA_W  head-of-queue word, valid while `empty`=0.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `full`  out  1  `count`==DEPTH.
- `empty`  out  1  `count`==0.
- `overflow`  out  1  sticky error flag, present only with `SYNC_FIFO_ERR_EN`.
- `underflow`  out  1  sticky error flag, present only with `SYNC_FIFO_ERR_EN`.

## Operation
- Internal write strobe: `wr_en` = `push` & (!`full` | `pop`).
- Internal read strobe: `rd_en` = `pop` & !`empty`.
- `wr_en`: `mem[wr_ptr]` <= `wr_data`, and `wr_ptr` increments.
- `rd_en`: `rd_ptr` increments.
- Both pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Occupancy update:
  - +1 on `wr_en` only.
  - −1 on `rd_en` only.
  - Unchanged when both or neither strobe fires.
- `full` and `empty` are decoded from `count`. No separate state machine; `count` is the state.
- `rd_data` = `mem[rd_ptr]`, combinational from storage. Its value is don't-care while `empty`=1.
- Simultaneous events:
  - Push and pop when empty: the push is accepted and the pop is ignored. `count` goes 0→1.
  - Push and pop when full: both are accepted. The write lands in the slot freed by the read, and `count` stays at DEPTH.
  - Push and pop otherwise: both are accepted and `count` is unchanged.
- A push while full with no pop is dropped. Storage, `wr_ptr` and `count` are unchanged.
- A pop while empty is ignored.
- Storage contents are not reset.
- Reset values, asserted asynchronously:
  - `wr_ptr`=0, `rd_ptr`=0, `count`=0.
  - `full`=0, `empty`=1.
  - `overflow`=0, `underflow`=0.
- Reset mid-operation discards all queued entries. The first push after deassertion writes slot 0.

## Timing
- All state updates on the rising edge of `clk`.
- Write-to-read latency: a word pushed at edge N appears on `rd_data` after edge N, so it is readable in cycle N+1.
- Pop latency: `rd_data` advances to the next entry after the popping edge.
- `count`, `full` and `empty` reflect the edge just taken, with no further delay.
- `push` and `pop` are sampled only at the clock edge. No combinational path exists from `push`/`pop` to any output.

## Configuration
- `SYNC_FIFO_ERR_EN` defined:
  - `overflow` sets on any cycle with `push` & `full` & !`pop`.
  - `underflow` sets on any cycle with `pop` & `empty`.
  - Both hold until `reset`.
- `SYNC_FIFO_ERR_EN` undefined:
  - Both ports and their logic are absent.
  - Dropped and ignored requests are silent.
  - All other behaviour is identical.

## Test plan
- Reset then idle: assert `reset`=0 mid-cycle -> `count`=0, `empty`=1 and `full`=0 immediately, with no clock edge needed.
- Fill and drain, DEPTH=4: push 0xA1, 0xA2, 0xA3, 0xA4 -> `full`=1 and `count`=4. Then pop ×4 -> `rd_data` sequence A1, A2, A3, A4 and `empty`=1.
- Overflow: from full, push 0xFF without pop -> `count` stays 4 and the head stays 0xA1. With `SYNC_FIFO_ERR_EN`, `overflow`=1 and stays 1 afterwards.
- Simultaneous push/pop:
  - When empty: push 0x55 with pop -> `count`=1 and `rd_data`=0x55. With the macro, `underflow`=1.
  - When full: push 0x66 with pop -> `count`=4, and 0x66 becomes the tail.
- Pointer wrap: run 10 alternating push/pop pairs with incrementing data -> each popped word equals the word pushed one cycle earlier, and `count` oscillates 0/1.
- Reset mid-operation: with 3 entries queued, pulse `reset` low -> `count`=0 and `empty`=1. A subsequent push of 0x77 then pop returns 0x77.
